// File: rtl/ej32_pkg.sv
// Shared types for the eJ32 data-stack unit: stack request encoding,
// sequencer states and the default RAM depth.
package ej32_pkg;

  typedef enum logic [2:0] {
    SS_NOP  = 3'd0,
    SS_PUSH = 3'd1,
    SS_POP  = 3'd2,
    SS_SETS = 3'd3,
    SS_PICK = 3'd4
  } ss_op_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REFILL  = 2'd1,
    ST_PICK_RD = 2'd2,
    ST_PICK_WB = 2'd3
  } ss_state_t;

  localparam int SS_DEPTH_DFLT = 64;

endpackage

// File: rtl/ej32_dstack_ss_ram.sv
// Single-port RAM with registered read data for the deep stack entries.
// No reset on the array or the read register so it maps onto block RAM.
module ss_ram #(
  parameter int DSZ   = 32,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           we,
  input  logic [AW-1:0]  addr,
  input  logic [DSZ-1:0] wdata,
  output logic [DSZ-1:0] rdata
);

  logic [DSZ-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ej32_dstack.sv
// eJ32 data stack: NOS register, prefetched third entry (nn) and a RAM for the
// rest. Requests are accepted only in ST_IDLE; busy_o marks REFILL/PICK cycles.
module ej32_dstack
  import ej32_pkg::*;
#(
  parameter int DSZ      = 32,
  parameter int SS_DEPTH = SS_DEPTH_DFLT,
  parameter int SSZ      = $clog2(SS_DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr_i,
  input  logic [2:0]     op_i,
  input  logic [DSZ-1:0] t_i,
  output logic [DSZ-1:0] s_o,
  output logic           busy_o,
  output logic [DSZ-1:0] dat_o,
  output logic           dat_x,
  output logic [SSZ:0]   depth_o,
  output logic           ovf_o,
  output logic           udf_o
);

  localparam logic [SSZ:0]   D_ONE  = (SSZ+1)'(1);
  localparam logic [SSZ:0]   D_TWO  = (SSZ+1)'(2);
  localparam logic [SSZ:0]   D_FULL = (SSZ+1)'(SS_DEPTH + 1);
  localparam logic [SSZ-1:0] A_TWO  = SSZ'(2);

  ss_state_t      state, state_n;
  ss_op_t         op;
  logic [DSZ-1:0] nn, nn_n, s_n, dat_n;
  logic [SSZ:0]   depth_n, sp, pick_idx;
  logic [SSZ-1:0] pick_addr, pick_addr_n;
  logic           datx_n, ovf_n, udf_n, busy_n;
  logic           ram_we;
  logic [SSZ-1:0] ram_addr;
  logic [DSZ-1:0] ram_rdata;

  assign op       = ss_op_t'(op_i);
  assign pick_idx = t_i[SSZ:0];
  // NOS is valid exactly when depth is nonzero, so RAM occupancy follows from depth.
  assign sp       = (depth_o == '0) ? '0 : depth_o - D_ONE;

  ss_ram #(.DSZ(DSZ), .DEPTH(SS_DEPTH), .AW(SSZ)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (s_o),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_n     = state;
    s_n         = s_o;
    nn_n        = nn;
    depth_n     = depth_o;
    dat_n       = dat_o;
    datx_n      = 1'b0;
    ovf_n       = ovf_o;
    udf_n       = udf_o;
    pick_addr_n = pick_addr;
    ram_we      = 1'b0;
    ram_addr    = sp[SSZ-1:0];
    unique case (state)
      ST_IDLE: begin
        case (op)
          SS_PUSH: begin
            if (depth_o == D_FULL) begin
              ovf_n = 1'b1;
            end else begin
              s_n     = t_i;
              depth_n = depth_o + D_ONE;
              if (depth_o != '0) begin
                ram_we = 1'b1;
                nn_n   = s_o;
              end
            end
          end
          SS_POP: begin
            if (depth_o == '0) begin
              udf_n = 1'b1;
            end else begin
              s_n     = nn;
              depth_n = depth_o - D_ONE;
              // Another element remains in RAM: fetch the new ram[sp-1] into nn.
              if (sp >= D_TWO) begin
                ram_addr = sp[SSZ-1:0] - A_TWO;
                state_n  = ST_REFILL;
              end
            end
          end
          SS_SETS: s_n = t_i;
          SS_PICK: begin
            if (pick_idx >= depth_o) begin
              dat_n  = '0;
              datx_n = 1'b1;
              udf_n  = 1'b1;
            end else if (pick_idx == '0) begin
              dat_n  = s_o;
              datx_n = 1'b1;
            end else begin
              pick_addr_n = sp[SSZ-1:0] - pick_idx[SSZ-1:0];
              state_n     = ST_PICK_RD;
            end
          end
          default: ;
        endcase
      end
      ST_REFILL: begin
        nn_n    = ram_rdata;
        state_n = ST_IDLE;
      end
      ST_PICK_RD: begin
        ram_addr = pick_addr;
        state_n  = ST_PICK_WB;
      end
      ST_PICK_WB: begin
        dat_n   = ram_rdata;
        datx_n  = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    if (clr_i) begin
      state_n = ST_IDLE;
      s_n     = '0;
      depth_n = '0;
      dat_n   = '0;
      datx_n  = 1'b0;
      ovf_n   = 1'b0;
      udf_n   = 1'b0;
      ram_we  = 1'b0;
    end
    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      s_o       <= '0;
      nn        <= '0;
      depth_o   <= '0;
      busy_o    <= 1'b0;
      dat_o     <= '0;
      dat_x     <= 1'b0;
      ovf_o     <= 1'b0;
      udf_o     <= 1'b0;
      pick_addr <= '0;
    end else begin
      state     <= state_n;
      s_o       <= s_n;
      nn        <= nn_n;
      depth_o   <= depth_n;
      busy_o    <= busy_n;
      dat_o     <= dat_n;
      dat_x     <= datx_n;
      ovf_o     <= ovf_n;
      udf_o     <= udf_n;
      pick_addr <= pick_addr_n;
    end
  end

endmodule
